// File: rtl/sd_slot_arbiter.sv
// sd_slot_arbiter: round-robin sharing of the user_io SD block channel between two image slots,
// with buffer-side routing to the owner and an ack-wait watchdog.
module sd_slot_arbiter #(
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] req0_lba,
  input  logic [31:0] req1_lba,
  input  logic        req0_rd,
  input  logic        req1_rd,
  input  logic        req0_wr,
  input  logic        req1_wr,
  input  logic [7:0]  req0_buff_din,
  input  logic [7:0]  req1_buff_din,
  output logic        req0_busy,
  output logic        req1_busy,
  output logic        req0_ack,
  output logic        req1_ack,
  output logic        req0_buff_wr,
  output logic        req1_buff_wr,
  output logic        req0_done,
  output logic        req1_done,
  output logic        req0_err,
  output logic        req1_err,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] XFER = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;
  logic [2:0]           state;
  logic [1:0]           prev, pending, lvl, rise, gnt_mask, gnt_oh;
  logic                 last_grant, owner, gnt, gnt_rd, granting;
  logic [TIMEOUT_W-1:0] cnt;
  always_comb begin
    lvl      = {req1_rd | req1_wr, req0_rd | req0_wr};
    rise     = lvl & ~prev;
    gnt      = (&pending) ? ~last_grant : pending[1];
    gnt_oh   = gnt ? 2'b10 : 2'b01;
    gnt_rd   = gnt ? req1_rd : req0_rd;
    granting = (state == IDLE) && (|pending);
    gnt_mask = granting ? gnt_oh : 2'b00;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= lvl;
      pending    <= 2'b00;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      sd_lba     <= '0;
      sd_rd      <= 2'b00;
      sd_wr      <= 2'b00;
    end else begin
      prev    <= lvl;
      pending <= (pending & ~gnt_mask) | rise;
      case (state)
        IDLE: if (granting) begin
          state      <= REQ;
          owner      <= gnt;
          last_grant <= gnt;
          sd_lba     <= gnt ? req1_lba : req0_lba;
          sd_rd      <= gnt_rd ? gnt_oh : 2'b00;
          sd_wr      <= gnt_rd ? 2'b00 : gnt_oh;
          cnt        <= '0;
        end
        REQ: if (sd_ack || (&cnt)) begin
          state <= sd_ack ? XFER : ERR;
          sd_rd <= 2'b00;
          sd_wr <= 2'b00;
        end else begin
          cnt <= cnt + TIMEOUT_W'(1);
        end
        XFER: if (!sd_ack) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  // Host-side strobes only reach the owner, and only while it is transferring.
  always_comb begin
    req0_ack     = (state == XFER) && !owner && sd_ack;
    req1_ack     = (state == XFER) && owner && sd_ack;
    req0_buff_wr = (state == XFER) && !owner && sd_buff_wr;
    req1_buff_wr = (state == XFER) && owner && sd_buff_wr;
    req0_done    = (state == DONE) && !owner;
    req1_done    = (state == DONE) && owner;
    req0_err     = (state == ERR) && !owner;
    req1_err     = (state == ERR) && owner;
    req0_busy    = pending[0] || (!owner && state != IDLE);
    req1_busy    = pending[1] || (owner && state != IDLE);
    sd_buff_din  = (state != IDLE && owner) ? req1_buff_din : req0_buff_din;
  end
endmodule

// File: tb/tb_sd_slot_arbiter.sv
// tb_sd_slot_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_sd_slot_arbiter;
  localparam int TW = 4;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] req0_lba = '0, req1_lba = '0;
  logic        req0_rd = 1'b0, req1_rd = 1'b0, req0_wr = 1'b0, req1_wr = 1'b0;
  logic [7:0]  req0_buff_din = '0, req1_buff_din = '0;
  logic        req0_busy, req1_busy, req0_ack, req1_ack, req0_buff_wr, req1_buff_wr;
  logic        req0_done, req1_done, req0_err, req1_err;
  logic [31:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr;
  logic        sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_din;
  int checks = 0;
  int errors = 0;

  sd_slot_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .req0_lba(req0_lba), .req1_lba(req1_lba),
    .req0_rd(req0_rd), .req1_rd(req1_rd), .req0_wr(req0_wr), .req1_wr(req1_wr),
    .req0_buff_din(req0_buff_din), .req1_buff_din(req1_buff_din),
    .req0_busy(req0_busy), .req1_busy(req1_busy), .req0_ack(req0_ack), .req1_ack(req1_ack),
    .req0_buff_wr(req0_buff_wr), .req1_buff_wr(req1_buff_wr),
    .req0_done(req0_done), .req1_done(req1_done), .req0_err(req0_err), .req1_err(req1_err),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic clear_inputs;
    {req0_rd, req1_rd, req0_wr, req1_wr, sd_ack, sd_buff_wr} = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Model: one transaction record (who, op, lba, cycles waited, acked, finishing)
  // plus a set of outstanding requests served alternately.
  bit [1:0]    m_prev, m_pend;
  int          m_last, m_cur, m_wrap, m_wait;
  bit          m_rd, m_acked;
  logic [31:0] m_lba;

  function automatic logic [1:0] oh(int n);
    return n == 1 ? 2'b10 : 2'b01;
  endfunction

  task automatic model_init;
    m_prev = {req1_rd | req1_wr, req0_rd | req0_wr};
    m_pend = '0; m_last = 1; m_cur = -1; m_wrap = 0; m_wait = 0;
    m_rd = 0; m_acked = 0; m_lba = '0;
  endtask

  task automatic model_step;
    bit [1:0] lvl, rise, np;
    int g;
    lvl = {req1_rd | req1_wr, req0_rd | req0_wr};
    rise = lvl & ~m_prev;
    m_prev = lvl;
    np = m_pend | rise;
    if (m_wrap != 0) begin
      m_wrap = 0;
      m_cur = -1;
    end else if (m_cur < 0) begin
      if (m_pend != 0) begin
        g = (m_pend == 2'b11) ? 1 - m_last : (m_pend[1] ? 1 : 0);
        m_cur = g; m_last = g;
        m_rd = (g == 1) ? req1_rd : req0_rd;
        m_lba = (g == 1) ? req1_lba : req0_lba;
        m_wait = 0; m_acked = 0;
        np[g] = rise[g];
      end
    end else if (!m_acked) begin
      if (sd_ack) m_acked = 1;
      else if (m_wait == (1 << TW) - 1) m_wrap = 2;
      else m_wait++;
    end else if (!sd_ack) begin
      m_wrap = 1;
    end
    m_pend = np;
  endtask

  task automatic test_reset;
    req0_lba = 32'hDEAD_BEEF;
    req0_rd = 1'b1;
    do_reset();
    checks++;
    if ({sd_rd, sd_wr, sd_lba, req0_busy, req1_busy, req0_done, req1_done, req0_err, req1_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs rd=%b wr=%b lba=%h busy=%b%b", sd_rd, sd_wr, sd_lba, req1_busy, req0_busy);
    end
    repeat (3) tick();
    checks++;
    if (sd_rd !== 2'b00 || req0_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_level rd=%b busy0=%b required rd=00 busy0=0", sd_rd, req0_busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read;
    do_reset();
    req0_lba = 32'h0000_1234;
    req0_rd = 1'b1;
    tick();
    checks++;
    if (sd_rd !== 2'b00 || req0_busy !== 1'b1) begin
      errors++;
      $display("FAIL read_pending rd=%b busy0=%b required rd=00 busy0=1", sd_rd, req0_busy);
    end
    tick();
    checks++;
    if (sd_rd !== 2'b01 || sd_wr !== 2'b00 || sd_lba !== 32'h1234) begin
      errors++;
      $display("FAIL read_strobe rd=%b wr=%b lba=%h required rd=01 wr=00 lba=00001234", sd_rd, sd_wr, sd_lba);
    end
    repeat (4) tick();
    sd_ack = 1'b1;
    tick();
    checks++;
    if (sd_rd !== 2'b00 || req0_ack !== 1'b1 || req1_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_ack rd=%b ack0=%b ack1=%b required rd=00 ack0=1 ack1=0", sd_rd, req0_ack, req1_ack);
    end
    for (int i = 0; i < 600; i++) begin
      sd_buff_wr = 1'($urandom);
      tick();
      checks++;
      if (req0_buff_wr !== sd_buff_wr || req1_buff_wr !== 1'b0 || req0_ack !== 1'b1 || req0_done !== 1'b0) begin
        errors++;
        $display("FAIL read_hold cycle=%0d bw0=%b bw1=%b ack0=%b done0=%b required bw0=%b bw1=0 ack0=1 done0=0",
                 i, req0_buff_wr, req1_buff_wr, req0_ack, req0_done, sd_buff_wr);
      end
    end
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    checks++;
    if (req0_done !== 1'b1 || req1_done !== 1'b0 || req0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_done done0=%b done1=%b ack0=%b required 1 0 0", req0_done, req1_done, req0_ack);
    end
    tick();
    checks++;
    if (req0_done !== 1'b0 || req0_busy !== 1'b0 || sd_rd !== 2'b00) begin
      errors++;
      $display("FAIL read_idle done0=%b busy0=%b rd=%b required 0 0 00", req0_done, req0_busy, sd_rd);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_simultaneous;
    do_reset();
    req0_lba = 32'h10; req1_lba = 32'h20;
    req0_wr = 1'b1; req1_rd = 1'b1;
    repeat (2) tick();
    checks++;
    if (sd_wr !== 2'b01 || sd_rd !== 2'b00 || sd_lba !== 32'h10 || req1_busy !== 1'b1) begin
      errors++;
      $display("FAIL pair_first wr=%b rd=%b lba=%h busy1=%b required wr=01 rd=00 lba=10 busy1=1", sd_wr, sd_rd, sd_lba, req1_busy);
    end
    sd_ack = 1'b1;
    repeat (2) tick();
    sd_ack = 1'b0;
    tick();
    checks++;
    if (req0_done !== 1'b1 || {sd_rd, sd_wr} !== 4'b0) begin
      errors++;
      $display("FAIL pair_done0 done0=%b rd=%b wr=%b required 1 00 00", req0_done, sd_rd, sd_wr);
    end
    tick();
    checks++;
    if ({sd_rd, sd_wr} !== 4'b0) begin
      errors++;
      $display("FAIL pair_gap rd=%b wr=%b required 00 00", sd_rd, sd_wr);
    end
    tick();
    checks++;
    if (sd_rd !== 2'b10 || sd_wr !== 2'b00 || sd_lba !== 32'h20) begin
      errors++;
      $display("FAIL pair_second rd=%b wr=%b lba=%h required rd=10 wr=00 lba=20", sd_rd, sd_wr, sd_lba);
    end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    checks++;
    if (req1_done !== 1'b1 || req0_done !== 1'b0) begin
      errors++;
      $display("FAIL pair_done1 done1=%b done0=%b required 1 0", req1_done, req0_done);
    end
    clear_inputs();
    tick();
    req0_rd = 1'b1;
    repeat (2) tick();
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    repeat (2) tick();
    clear_inputs();
    tick();
    req0_rd = 1'b1; req1_wr = 1'b1;
    repeat (2) tick();
    checks++;
    if (sd_wr !== 2'b10 || sd_rd !== 2'b00 || req0_busy !== 1'b1) begin
      errors++;
      $display("FAIL pair_rr wr=%b rd=%b busy0=%b required wr=10 rd=00 busy0=1", sd_wr, sd_rd, req0_busy);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_buffer_routing;
    do_reset();
    req0_buff_din = 8'h3C; req1_buff_din = 8'hA5;
    req1_wr = 1'b1;
    repeat (2) tick();
    checks++;
    if (sd_wr !== 2'b10 || sd_buff_din !== 8'hA5) begin
      errors++;
      $display("FAIL buf_req wr=%b din=%h required wr=10 din=a5", sd_wr, sd_buff_din);
    end
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      sd_buff_wr = i[0];
      tick();
      checks++;
      if (req1_buff_wr !== sd_buff_wr || req0_buff_wr !== 1'b0 || sd_buff_din !== 8'hA5 || req0_ack !== 1'b0) begin
        errors++;
        $display("FAIL buf_route cycle=%0d bw1=%b bw0=%b din=%h ack0=%b required bw1=%b bw0=0 din=a5 ack0=0",
                 i, req1_buff_wr, req0_buff_wr, sd_buff_din, req0_ack, sd_buff_wr);
      end
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;
    repeat (2) tick();
    checks++;
    if (sd_buff_din !== 8'h3C) begin
      errors++;
      $display("FAIL buf_idle din=%h required 3c", sd_buff_din);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    req0_rd = 1'b1;
    repeat (2) tick();
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if (i < 16 && (req0_err !== 1'b0 || sd_rd !== 2'b01)) begin
        errors++;
        $display("FAIL timeout_wait cycle=%0d err0=%b rd=%b required 0 01", i, req0_err, sd_rd);
      end else if (i == 16 && (req0_err !== 1'b1 || sd_rd !== 2'b00 || req0_done !== 1'b0)) begin
        errors++;
        $display("FAIL timeout_err err0=%b rd=%b done0=%b required 1 00 0", req0_err, sd_rd, req0_done);
      end
    end
    tick();
    checks++;
    if (req0_err !== 1'b0 || req0_busy !== 1'b0 || req0_done !== 1'b0 || sd_rd !== 2'b00) begin
      errors++;
      $display("FAIL timeout_after err0=%b busy0=%b done0=%b rd=%b required 0 0 0 00", req0_err, req0_busy, req0_done, sd_rd);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_xfer;
    do_reset();
    req0_rd = 1'b1;
    repeat (2) tick();
    sd_ack = 1'b1;
    tick();
    checks++;
    if (req0_ack !== 1'b1) begin
      errors++;
      $display("FAIL midrst_xfer ack0=%b required 1", req0_ack);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({sd_rd, sd_wr} !== 4'b0 || req0_busy !== 1'b0 || req0_ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop rd=%b wr=%b busy0=%b ack0=%b required 00 00 0 0", sd_rd, sd_wr, req0_busy, req0_ack);
    end
    reset = 1'b0;
    sd_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (req0_done !== 1'b0 || req0_err !== 1'b0 || sd_rd !== 2'b00) begin
        errors++;
        $display("FAIL midrst_quiet cycle=%0d done0=%b err0=%b rd=%b required 0 0 00", i, req0_done, req0_err, sd_rd);
      end
    end
    req0_rd = 1'b0;
    tick();
    req0_rd = 1'b1;
    repeat (2) tick();
    checks++;
    if (sd_rd !== 2'b01) begin
      errors++;
      $display("FAIL midrst_restart rd=%b required 01", sd_rd);
    end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    repeat (2) tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious_ack;
    do_reset();
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({sd_rd, sd_wr, req0_ack, req1_ack, req0_buff_wr, req1_buff_wr, req0_done, req1_done,
           req0_err, req1_err, req0_busy, req1_busy} !== '0) begin
        errors++;
        $display("FAIL spurious cycle=%0d rd=%b wr=%b ack=%b%b bw=%b%b done=%b%b err=%b%b busy=%b%b required all 0",
                 i, sd_rd, sd_wr, req1_ack, req0_ack, req1_buff_wr, req0_buff_wr, req1_done, req0_done,
                 req1_err, req0_err, req1_busy, req0_busy);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random;
    int p_ack;
    bit act, xf;
    logic [1:0] e_rd, e_wr, e_ack, e_bw, e_done, e_err, e_busy;
    logic [7:0] e_din;
    clear_inputs();
    do_reset();
    model_init();
    p_ack = 40;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) p_ack = ($urandom_range(0, 1) == 1) ? 40 : 3;
      if ($urandom_range(0, 7) == 0) req0_rd = ~req0_rd;
      if ($urandom_range(0, 7) == 0) req0_wr = ~req0_wr;
      if ($urandom_range(0, 7) == 0) req1_rd = ~req1_rd;
      if ($urandom_range(0, 7) == 0) req1_wr = ~req1_wr;
      req0_lba = $urandom; req1_lba = $urandom;
      req0_buff_din = 8'($urandom); req1_buff_din = 8'($urandom);
      sd_ack = ($urandom_range(0, 99) < p_ack);
      sd_buff_wr = 1'($urandom);
      tick();
      model_step();
      act = m_cur >= 0 && m_wrap == 0 && !m_acked;
      xf = m_cur >= 0 && m_wrap == 0 && m_acked;
      e_rd = (act && m_rd) ? oh(m_cur) : 2'b00;
      e_wr = (act && !m_rd) ? oh(m_cur) : 2'b00;
      e_ack = (xf && sd_ack) ? oh(m_cur) : 2'b00;
      e_bw = (xf && sd_buff_wr) ? oh(m_cur) : 2'b00;
      e_done = (m_wrap == 1) ? oh(m_cur) : 2'b00;
      e_err = (m_wrap == 2) ? oh(m_cur) : 2'b00;
      e_busy = m_pend | ((m_cur >= 0) ? oh(m_cur) : 2'b00);
      e_din = (m_cur == 1) ? req1_buff_din : req0_buff_din;
      checks++;
      if ({sd_rd, sd_wr, sd_lba, sd_buff_din, req1_ack, req0_ack, req1_buff_wr, req0_buff_wr,
           req1_done, req0_done, req1_err, req0_err, req1_busy, req0_busy} !==
          {e_rd, e_wr, m_lba, e_din, e_ack, e_bw, e_done, e_err, e_busy}) begin
        errors++;
        $display("FAIL random cycle=%0d got rd=%b wr=%b lba=%h din=%h ack=%b%b bw=%b%b done=%b%b err=%b%b busy=%b%b want rd=%b wr=%b lba=%h din=%h ack=%b bw=%b done=%b err=%b busy=%b",
                 c, sd_rd, sd_wr, sd_lba, sd_buff_din, req1_ack, req0_ack, req1_buff_wr, req0_buff_wr,
                 req1_done, req0_done, req1_err, req0_err, req1_busy, req0_busy,
                 e_rd, e_wr, m_lba, e_din, e_ack, e_bw, e_done, e_err, e_busy);
      end
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_buffer_routing();
    test_timeout();
    test_reset_mid_xfer();
    test_spurious_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
